// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD display counter.
//   bcd_digit_t  : one 4-bit BCD digit
//   SEG_*        : active-low seven-segment codes, bit 7 = decimal point (off = 1)
//   bcd_sanitize : maps an out-of-range digit (>9) to 0
package bcd_disp_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder.
//   digit : 4-bit BCD digit
//   blank : 1 forces all segments off
//   seg   : active-low segments, bit 7 = decimal point (always off)
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  bcd_digit_t  digit,
    input  logic        blank,
    output logic [7:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_counter.sv
// Cascaded BCD up/down counter with prescaler and registered seven-segment outputs.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : prescaler/count enable
//   up_dn      : 1 = count up, 0 = count down (sampled on the step cycle only)
//   clear      : synchronous zero of count and prescaler (highest priority)
//   load       : synchronous load of load_val (digits >9 load as 0)
//   load_val   : BCD load value, digit 0 in [3:0]
//   blank_lz   : leading-zero blanking enable
//   count_bcd  : registered BCD count
//   seg_out    : registered active-low segments, digit i in [8i+7:8i]
//   tick, wrap : one-cycle pulses coincident with the updated count
module bcd_display_counter
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 16666667
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    blank_lz,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [8*NUM_DIGITS-1:0] seg_out,
    output logic                    tick,
    output logic                    wrap
);

    localparam int              PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]        pre_q;
    logic [4*NUM_DIGITS-1:0] cnt_q;
    logic [8*NUM_DIGITS-1:0] seg_q;
    logic                    tick_q;
    logic                    wrap_q;

    logic                    step;
    logic [4*NUM_DIGITS-1:0] cnt_step;
    logic                    wrap_step;
    logic [4*NUM_DIGITS-1:0] load_clean;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [8*NUM_DIGITS-1:0] seg_d;

    // clear/load take the cycle over, so no step fires alongside them
    assign step = en && (pre_q == PRE_MAX) && !clear && !load;

    // Ripple increment/decrement: a digit rolls (9->0 up, 0->9 down) and passes
    // the carry/borrow upward; a carry out of the top digit is a wrap.
    always_comb begin
        logic       carry;
        bcd_digit_t dig;
        cnt_step = cnt_q;
        carry    = 1'b1;
        dig      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (dig == 4'd9) begin
                        cnt_step[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_step[4*i +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        cnt_step[4*i +: 4] = 4'd9;
                    end else begin
                        cnt_step[4*i +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap_step = carry;
    end

    always_comb begin
        load_clean = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clean[4*i +: 4] = bcd_sanitize(load_val[4*i +: 4]);
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (cnt_q[4*i +: 4] == 4'd0);
            blank_vec[i] = blank_lz && zero_above && (i != 0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_seg7_decode (
            .digit (cnt_q[4*g +: 4]),
            .blank (blank_vec[g]),
            .seg   (seg_d[8*g +: 8])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            seg_q  <= {NUM_DIGITS{SEG_0}};
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            tick_q <= step;
            wrap_q <= step && wrap_step;
            if (clear) begin
                pre_q <= '0;
                cnt_q <= '0;
            end else if (load) begin
                pre_q <= '0;
                cnt_q <= load_clean;
            end else if (en) begin
                if (pre_q == PRE_MAX) begin
                    pre_q <= '0;
                    cnt_q <= cnt_step;
                end else begin
                    pre_q <= pre_q + PRE_W'(1);
                end
            end
        end
    end

    assign count_bcd = cnt_q;
    assign seg_out   = seg_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Self-checking bench for bcd_display_counter (3 digits, 4 cycles per tick).
// A decimal reference model predicts each cycle's outputs into a scoreboard queue.
module tb_bcd_display_counter;

    localparam int ND = 3;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, up_dn, clear, load, blank_lz;
    logic [4*ND-1:0] load_val;
    logic [4*ND-1:0] count_bcd;
    logic [8*ND-1:0] seg_out;
    logic          tick, wrap;

    bcd_display_counter #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .blank_lz  (blank_lz),
        .count_bcd (count_bcd),
        .seg_out   (seg_out),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] cnt;
        logic        tick;
        logic        wrap;
        logic [23:0] seg;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_cnt = 0;
    int          m_pre = 0;
    logic        m_tick = 1'b0;
    logic        m_wrap = 1'b0;
    logic [23:0] m_seg  = 24'hC0C0C0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [23:0] enc(input int c, input logic blz);
        int d2, d1, d0;
        logic [7:0] s2, s1, s0;
        d2 = c / 100;
        d1 = (c / 10) % 10;
        d0 = c % 10;
        s2 = (blz && d2 == 0) ? 8'hFF : seg_of(d2);
        s1 = (blz && d2 == 0 && d1 == 0) ? 8'hFF : seg_of(d1);
        s0 = seg_of(d0);
        return {s2, s1, s0};
    endfunction

    function automatic logic [11:0] to_bcd(input int c);
        logic [11:0] r;
        r[11:8] = 4'((c / 100) % 10);
        r[7:4]  = 4'((c / 10) % 10);
        r[3:0]  = 4'(c % 10);
        return r;
    endfunction

    function automatic int from_load(input logic [11:0] v);
        int d2, d1, d0;
        d2 = (v[11:8] > 4'd9) ? 0 : int'(v[11:8]);
        d1 = (v[7:4]  > 4'd9) ? 0 : int'(v[7:4]);
        d0 = (v[3:0]  > 4'd9) ? 0 : int'(v[3:0]);
        return d2 * 100 + d1 * 10 + d0;
    endfunction

    // One clock: drive inputs on the falling edge, predict, compare after the rising edge.
    task automatic cyc(input logic i_en, input logic i_up, input logic i_clr,
                       input logic i_ld, input logic [11:0] i_lv, input logic i_blz,
                       output logic o_tick);
        exp_t e;
        exp_t g;
        @(negedge clk);
        en = i_en; up_dn = i_up; clear = i_clr; load = i_ld; load_val = i_lv; blank_lz = i_blz;
        m_seg = enc(m_cnt, i_blz);
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (i_clr) begin
            m_cnt = 0; m_pre = 0;
        end else if (i_ld) begin
            m_cnt = from_load(i_lv); m_pre = 0;
        end else if (i_en) begin
            if (m_pre == TD - 1) begin
                m_pre  = 0;
                m_tick = 1'b1;
                if (i_up) begin
                    m_wrap = (m_cnt == 999);
                    m_cnt  = (m_cnt + 1) % 1000;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + 999) % 1000;
                end
            end else begin
                m_pre++;
            end
        end
        e.cnt = to_bcd(m_cnt); e.tick = m_tick; e.wrap = m_wrap; e.seg = m_seg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check_eq("count", 32'(count_bcd), 32'(g.cnt));
        check_eq("tick",  32'(tick),      32'(g.tick));
        check_eq("wrap",  32'(wrap),      32'(g.wrap));
        check_eq("seg",   32'(seg_out),   32'(g.seg));
        o_tick = tick;
    endtask

    initial begin
        logic t;
        int   lat;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
        load_val = '0; blank_lz = 1'b1;
        #12;
        check_eq("rst_count", 32'(count_bcd), 32'h000);
        check_eq("rst_seg",   32'(seg_out),   32'hC0C0C0);
        check_eq("rst_tick",  32'(tick),      32'h0);
        check_eq("rst_wrap",  32'(wrap),      32'h0);
        rst = 1'b0;

        // Count up 000 -> 010, one tick per 4 enabled cycles
        for (int i = 0; i < 4 * 10 + 2; i++) cyc(1, 1, 0, 0, 12'h000, 0, t);
        check_eq("count_010", 32'(count_bcd), 32'h010);

        // 999 + 1 wraps to 000
        cyc(1, 1, 0, 1, 12'h999, 0, t);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 12'h000, 0, t);

        // 000 - 1 wraps to 999, then 998 without wrap
        cyc(1, 0, 0, 1, 12'h000, 0, t);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 12'h000, 0, t);
        check_eq("count_998", 32'(count_bcd), 32'h998);

        // up_dn toggled mid-period only matters on the step cycle
        for (int i = 0; i < 8; i++) cyc(1, 1'(i % 2), 0, 0, 12'h000, 0, t);

        // clear + load together on the step cycle
        for (int i = 0; i < 8 && m_pre != TD - 1; i++) cyc(1, 1, 0, 0, 12'h000, 0, t);
        cyc(1, 1, 1, 1, 12'h123, 0, t);
        check_eq("clr_ld_count", 32'(count_bcd), 32'h000);
        check_eq("clr_ld_tick",  32'(tick),      32'h0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 12'h000, 0, t);

        // en=0 holds prescaler and count
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 12'h000, 0, t);

        // Leading-zero blanking
        cyc(0, 1, 0, 1, 12'h007, 1, t);
        cyc(0, 1, 0, 0, 12'h000, 1, t);
        check_eq("blank_007", 32'(seg_out), 32'hFFFFF8);
        cyc(0, 1, 0, 1, 12'h000, 1, t);
        cyc(0, 1, 0, 0, 12'h000, 1, t);
        check_eq("blank_000", 32'(seg_out), 32'hFFFFC0);
        cyc(0, 1, 0, 1, 12'h405, 1, t);
        cyc(0, 1, 0, 0, 12'h000, 1, t);

        // Invalid digits load as 0
        cyc(0, 1, 0, 1, 12'hF5A, 0, t);
        check_eq("load_F5A", 32'(count_bcd), 32'h050);

        // Reach 456, go mid-period, then async reset
        cyc(1, 1, 0, 1, 12'h455, 0, t);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 12'h000, 0, t);
        check_eq("count_456", 32'(count_bcd), 32'h456);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_count", 32'(count_bcd), 32'h000);
        check_eq("arst_seg",   32'(seg_out),   32'hC0C0C0);
        check_eq("arst_tick",  32'(tick),      32'h0);
        rst = 1'b0;
        m_cnt = 0; m_pre = 0; m_tick = 1'b0; m_wrap = 1'b0; m_seg = 24'hC0C0C0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 0, 0, 12'h000, 0, t);
            if (t && lat == 0) lat = i;
        end
        check_eq("arst_tick_latency", 32'(lat), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
